// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the encryption core.
// Used by both the one-round and the AES_UNROLL2_EN two-round builds.
package aes_pkg;

  localparam int AES_NR = 10;

  // Column-major block: byte i (FIPS in[i]) lives in element [15-i], so bits [127:120] are byte 0.
  typedef logic [15:0][7:0] aes_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } aes_fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] inv;
  logic [7:0] sq;
  logic [15:0] dd;

  // x^254 == x^-1 (and maps 0 to 0); built from the squares x^2 .. x^128.
  always_comb begin
    inv = 8'h01;
    sq  = in_byte;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    dd       = {inv, inv};
    out_byte = inv ^ dd[14:7] ^ dd[13:6] ^ dd[12:5] ^ dd[11:4] ^ 8'h63;
  end

endmodule

// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Define AES_UNROLL2_EN to chain two round stages per clock (5-cycle busy instead of 10).
module aes128_enc_core
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [127:0] plaintext,
  input  logic [127:0] secret,
  input  logic         we,
  output logic [127:0] cipher,
  output logic         busy
);

`ifdef AES_UNROLL2_EN
  localparam int STG = 2;
`else
  localparam int STG = 1;
`endif

  aes_fsm_t     fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] cipher_q, cipher_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done;

  logic [127:0] st_c  [STG+1];
  logic [127:0] key_c [STG+1];

  assign st_c[0]  = state_q;
  assign key_c[0] = rkey_q;

  for (genvar g = 0; g < STG; g++) begin : g_stage
    aes_state_t  s_in, s_sb, s_sr, s_mc;
    logic [31:0] w3, rot, sw, temp, w0n, w1n, w2n, w3n;
    logic [127:0] k_in, k_nx;
    logic [3:0]  r;
    logic        last;

    assign s_in = st_c[g];
    assign k_in = key_c[g];
    assign r    = rnd_q + 4'(g);
    assign last = (r == 4'(NR));

    for (genvar i = 0; i < 16; i++) begin : g_sb
      aes_sbox u_sbox (.in_byte(s_in[i]), .out_byte(s_sb[i]));
    end

    assign w3  = k_in[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    for (genvar j = 0; j < 4; j++) begin : g_kb
      aes_sbox u_sbox (.in_byte(rot[8*j +: 8]), .out_byte(sw[8*j +: 8]));
    end

    assign temp = sw ^ {rcon(r), 24'h000000};
    assign w0n  = k_in[127:96] ^ temp;
    assign w1n  = k_in[95:64]  ^ w0n;
    assign w2n  = k_in[63:32]  ^ w1n;
    assign w3n  = w3 ^ w2n;
    assign k_nx = {w0n, w1n, w2n, w3n};

    // Byte (row rr, col c) sits at element 15-(4c+rr); ShiftRows pulls from column c+rr.
    always_comb begin
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
        for (int rr = 0; rr < 4; rr++) begin
          s_sr[15-(4*c+rr)] = s_sb[15-(4*((c+rr)%4)+rr)];
        end
      end
      for (int c = 0; c < 4; c++) begin
        a0 = s_sr[15-4*c];
        a1 = s_sr[14-4*c];
        a2 = s_sr[13-4*c];
        a3 = s_sr[12-4*c];
        s_mc[15-4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        s_mc[14-4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        s_mc[13-4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        s_mc[12-4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end

    assign st_c[g+1]  = (last ? s_sr : s_mc) ^ k_nx;
    assign key_c[g+1] = k_nx;
  end

  assign done = (rnd_q + 4'(STG - 1)) == 4'(NR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (we) fsm_d = RUN;
      RUN:     if (done) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (fsm_q == RUN);
    cipher = cipher_q;
  end

  // Strobes seen while RUN are dropped: inputs are only captured from IDLE.
  always_comb begin
    state_d  = state_q;
    rkey_d   = rkey_q;
    rnd_d    = rnd_q;
    cipher_d = cipher_q;
    if (fsm_q == IDLE) begin
      if (we) begin
        state_d = plaintext ^ secret;
        rkey_d  = secret;
        rnd_d   = 4'd1;
      end
    end else begin
      state_d = st_c[STG];
      rkey_d  = key_c[STG];
      rnd_d   = rnd_q + 4'(STG);
      if (done) cipher_d = st_c[STG];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= '0;
      rkey_q   <= '0;
      rnd_q    <= '0;
      cipher_q <= '0;
    end else begin
      state_q  <= state_d;
      rkey_q   <= rkey_d;
      rnd_q    <= rnd_d;
      cipher_q <= cipher_d;
    end
  end

endmodule
